// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: brings up a PLL from the 12 MHz reference clock,
// waits for a stable synchronized lock, then releases downstream reset.
// Failed lock attempts are retried a bounded number of times before the
// block parks in FAULT until enable is dropped.
module pll_reset_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       locked,
    output logic       pll_resetb,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RESET = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // One shared cycle counter serves every timed state; it only ever holds
    // values up to (longest interval - 1), so it never wraps while in use.
    localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT);
    localparam int RETRY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_t               cur_state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     next_cnt;
    logic [RETRY_W-1:0]   retries;
    logic [RETRY_W-1:0]   next_retries;
    logic [7:0]           next_llc;
    logic                 lock_meta;
    logic                 lock_s;

    assign state = cur_state;

    // Two-flop synchronizer for the raw PLL lock; only lock_s is used below.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, counter, retry and lock-loss bookkeeping; enable=0 overrides all.
    always_comb begin
        next_state   = cur_state;
        next_cnt     = cnt;
        next_retries = retries;
        next_llc     = lock_loss_count;
        if (!enable) begin
            next_state   = IDLE;
            next_retries = '0;
        end else begin
            case (cur_state)
                IDLE: next_state = PLL_RESET;
                PLL_RESET: begin
                    if (cnt == RESET_LAST) next_state = WAIT_LOCK;
                    else                   next_cnt   = cnt + CNT_W'(1);
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        next_state = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retries < RETRY_LIMIT) begin
                            next_retries = retries + RETRY_W'(1);
                            next_state   = PLL_RESET;
                        end else begin
                            next_state = FAULT;
                        end
                    end else begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s)                 next_state = WAIT_LOCK;
                    else if (cnt == STABLE_LAST) next_state = RUN;
                    else                         next_cnt   = cnt + CNT_W'(1);
                end
                RUN: begin
                    if (!lock_s) begin
                        next_state = PLL_RESET;
                        if (lock_loss_count != 8'hFF) next_llc = lock_loss_count + 8'd1;
                    end
                end
                FAULT: next_state = FAULT;
                default: next_state = IDLE;
            endcase
        end
        if (next_state != cur_state) next_cnt = '0;
        if (next_state == RUN && cur_state != RUN) next_retries = '0;
    end

    // State, counters and outputs; outputs decode the next state so they
    // change on the same edge as the state they belong to.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cur_state       <= IDLE;
            cnt             <= '0;
            retries         <= '0;
            lock_loss_count <= 8'd0;
            pll_resetb      <= 1'b0;
            sys_reset_n     <= 1'b0;
            ready           <= 1'b0;
            fault           <= 1'b0;
        end else begin
            cur_state       <= next_state;
            cnt             <= next_cnt;
            retries         <= next_retries;
            lock_loss_count <= next_llc;
            pll_resetb      <= (next_state == WAIT_LOCK) || (next_state == STABLE) ||
                               (next_state == RUN);
            sys_reset_n     <= (next_state == RUN);
            ready           <= (next_state == RUN);
            fault           <= (next_state == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a driver issues per-cycle
// stimulus and pushes the reference model's expected outputs; a monitor
// pops and compares after every clock edge and every async reset assertion.
module tb_pll_reset_sequencer;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int MR = 2;

    localparam int S_IDLE   = 0;
    localparam int S_PRST   = 1;
    localparam int S_WAIT   = 2;
    localparam int S_STABLE = 3;
    localparam int S_RUN    = 4;
    localparam int S_FAULT  = 5;

    typedef struct packed {
        logic [2:0] st;
        logic       prb;
        logic       srn;
        logic       rdy;
        logic       flt;
        logic [7:0] llc;
    } obs_t;

    logic       clock_in = 1'b0;
    logic       reset_n  = 1'b0;
    logic       enable   = 1'b0;
    logic       locked   = 1'b0;
    logic       pll_resetb;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [7:0] lock_loss_count;

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];

    int   m_state, m_time, m_retries, m_llc;
    logic m_meta, m_sync;

    logic count_edges = 1'b0;
    logic prev_prb    = 1'b0;
    int   rise_count  = 0;

    pll_reset_sequencer #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR)
    ) dut (
        .clock_in       (clock_in),
        .reset_n        (reset_n),
        .enable         (enable),
        .locked         (locked),
        .pll_resetb     (pll_resetb),
        .sys_reset_n    (sys_reset_n),
        .ready          (ready),
        .fault          (fault),
        .state          (state),
        .lock_loss_count(lock_loss_count)
    );

    // 12 MHz reference, scaled to a 10-unit period.
    always #5 clock_in = ~clock_in;

    task automatic model_reset();
        m_state   = S_IDLE;
        m_time    = 0;
        m_retries = 0;
        m_llc     = 0;
        m_meta    = 1'b0;
        m_sync    = 1'b0;
    endtask

    // Reference behaviour: m_time counts cycles already spent in the current state.
    task automatic model_step(input logic en, input logic lk);
        int   ns;
        logic ls;
        ls = m_sync;
        ns = m_state;
        if (!en) begin
            ns        = S_IDLE;
            m_retries = 0;
        end else begin
            case (m_state)
                S_IDLE: ns = S_PRST;
                S_PRST: if (m_time + 1 >= RC) ns = S_WAIT;
                S_WAIT: begin
                    if (ls) ns = S_STABLE;
                    else if (m_time + 1 >= LT) begin
                        if (m_retries < MR) begin
                            m_retries = m_retries + 1;
                            ns        = S_PRST;
                        end else begin
                            ns = S_FAULT;
                        end
                    end
                end
                S_STABLE: begin
                    if (!ls) ns = S_WAIT;
                    else if (m_time + 1 >= SC) ns = S_RUN;
                end
                S_RUN: begin
                    if (!ls) begin
                        ns    = S_PRST;
                        m_llc = (m_llc >= 255) ? 255 : m_llc + 1;
                    end
                end
                default: ns = m_state;
            endcase
        end
        if (ns == S_RUN && m_state != S_RUN) m_retries = 0;
        m_time  = (ns == m_state) ? m_time + 1 : 0;
        m_state = ns;
        m_sync  = m_meta;
        m_meta  = lk;
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.st  = 3'(m_state);
        o.prb = (m_state == S_WAIT) || (m_state == S_STABLE) || (m_state == S_RUN);
        o.srn = (m_state == S_RUN);
        o.rdy = (m_state == S_RUN);
        o.flt = (m_state == S_FAULT);
        o.llc = 8'(m_llc);
        return o;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the expected result.
    task automatic apply_stimulus(input logic en, input logic lk);
        @(negedge clock_in);
        enable = en;
        locked = lk;
        if (!reset_n) model_reset();
        else          model_step(en, lk);
        sb.push_back(model_out());
    endtask

    // Assert reset_n mid-cycle (no clock edge nearby), hold, release mid-cycle.
    task automatic pulse_reset(input int hold);
        @(posedge clock_in);
        #2;
        model_reset();
        sb.push_back(model_out());
        reset_n = 1'b0;
        repeat (hold) apply_stimulus(enable, locked);
        @(posedge clock_in);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic check_output();
        obs_t act;
        obs_t exp;
        act = {state, pll_resetb, sys_reset_n, ready, fault, lock_loss_count};
        if (count_edges && pll_resetb && !prev_prb) rise_count++;
        prev_prb = pll_resetb;
        if (sb.size() == 0) return;
        exp = sb.pop_front();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL outputs t=%0t got st=%0d prb=%b srn=%b rdy=%b flt=%b llc=%0d want st=%0d prb=%b srn=%b rdy=%b flt=%b llc=%0d",
                     $time, act.st, act.prb, act.srn, act.rdy, act.flt, act.llc,
                     exp.st, exp.prb, exp.srn, exp.rdy, exp.flt, exp.llc);
        end
    endtask

    // Monitor: compare after each clock edge and right after an async reset.
    initial begin
        forever begin
            @(posedge clock_in or negedge reset_n);
            #1;
            check_output();
        end
    end

    // Driver: directed scenarios, random segments, saturation and async reset.
    initial begin
        int   len;
        logic lk;
        logic en;
        model_reset();
        $display("[TB] start");

        repeat (3) apply_stimulus(1'b0, 1'b0);
        @(posedge clock_in);
        #3;
        reset_n = 1'b1;

        // Nominal bring-up: lock arrives 10 cycles after pll_resetb rises.
        for (int i = 0; i < 20 && m_state != S_WAIT; i++) apply_stimulus(1'b1, 1'b0);
        repeat (10) apply_stimulus(1'b1, 1'b0);
        repeat (2 + SC + 4) apply_stimulus(1'b1, 1'b1);

        // Lock loss in RUN, then relock.
        repeat (3) apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 40 && !(m_state == S_STABLE && m_time == 4); i++)
            apply_stimulus(1'b1, 1'b1);

        // Lock glitch inside STABLE.
        repeat (3) apply_stimulus(1'b1, 1'b0);
        repeat (2 + SC + 6) apply_stimulus(1'b1, 1'b1);

        // Timeout path to FAULT, then recovery through IDLE.
        repeat (2) apply_stimulus(1'b0, 1'b0);
        rise_count  = 0;
        count_edges = 1'b1;
        repeat (1 + (RC + LT) * (MR + 1) + 10) apply_stimulus(1'b1, 1'b0);
        count_edges = 1'b0;
        checks++;
        if (rise_count != MR + 1) begin
            errors++;
            $display("[TB] FAIL attempt_pulses got %0d want %0d", rise_count, MR + 1);
        end
        repeat (2) apply_stimulus(1'b0, 1'b0);
        repeat (30) apply_stimulus(1'b1, 1'b1);

        // Randomized segments of enable/lock levels.
        for (int seg = 0; seg < 120; seg++) begin
            len = $urandom_range(1, 60);
            lk  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) != 0);
            repeat (len) apply_stimulus(en, lk);
        end

        // Lock-loss counter saturation.
        repeat (30) apply_stimulus(1'b1, 1'b1);
        for (int k = 0; k < 260; k++) begin
            apply_stimulus(1'b1, 1'b0);
            repeat (22) apply_stimulus(1'b1, 1'b1);
        end
        checks++;
        if (lock_loss_count !== 8'd255) begin
            errors++;
            $display("[TB] FAIL llc_saturate got %0d want 255", lock_loss_count);
        end

        // Asynchronous reset in the middle of RUN, then a fresh bring-up.
        pulse_reset(2);
        repeat (RC + SC + 10) apply_stimulus(1'b1, 1'b1);

        @(posedge clock_in);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles pll_resetb is held low per PLL reset attempt (range 1..255).
REQ-002 Parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT_LOCK before an attempt fails (range 2..65535).
REQ-003 Parameter STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required before release (range 1..65535).
REQ-004 Parameter MAX_RETRIES, default 3: failed attempts tolerated before FAULT (range 0..15).
REQ-005 clock_in  input  1  12 MHz reference clock; the block runs only on this clock, never on the PLL output.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  level; high requests PLL bring-up, low forces IDLE.
REQ-008 locked  input  1  raw PLL LOCK, asynchronous to clock_in.
REQ-009 pll_resetb  output  1  drives PLL RESETB; low holds the PLL in reset.
REQ-010 sys_reset_n  output  1  active-low reset for downstream DDS logic; the consumer synchronizes it into its clock domain.
REQ-011 ready  output  1  high only in RUN.
REQ-012 fault  output  1  high only in FAULT.
REQ-013 state  output  3  current state encoding: IDLE=0, PLL_RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
REQ-014 lock_loss_count  output  8  count of RUN-to-lock-loss events; saturates at 255.

Function
REQ-015 locked SHALL pass through a 2-flop synchronizer; lock_s (2nd flop) is the only lock signal used, giving a 2-cycle detect latency.
REQ-016 All outputs SHALL be registered; state is the registered state value.
REQ-017 Regardless of state, enable=0 SHALL force IDLE on the next edge and clear the retry counter; lock_loss_count is kept.
REQ-018 IDLE: pll_resetb=0, sys_reset_n=0; enable=1 -> PLL_RESET.
REQ-019 PLL_RESET: pll_resetb=0, sys_reset_n=0; a counter loaded with 0 on entry advances each cycle; after exactly RESET_CYCLES cycles in PLL_RESET -> WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_resetb=1, sys_reset_n=0; lock_s=1 -> STABLE; if LOCK_TIMEOUT cycles elapse without lock_s -> retry handling (REQ-023).
REQ-021 STABLE: pll_resetb=1, sys_reset_n=0; counter restarts on entry; STABLE_CYCLES consecutive cycles with lock_s=1 -> RUN; any lock_s=0 -> WAIT_LOCK with timeout counter restarted (not a retry).
REQ-022 RUN: pll_resetb=1, sys_reset_n=1, ready=1; retry counter cleared on entry; lock_s=0 -> PLL_RESET, and sys_reset_n and ready SHALL be low from the cycle the transition takes effect; lock_loss_count increments by 1 (saturating at 255).
REQ-023 Retry handling: on timeout, if retries < MAX_RETRIES then retries+1 and -> PLL_RESET; otherwise -> FAULT.
REQ-024 FAULT: pll_resetb=0, sys_reset_n=0, fault=1; exit only by enable=0 (to IDLE) or reset_n.
REQ-025 Simultaneous enable=0 with any transition condition: enable=0 SHALL win.
REQ-026 lock_s=1 on the same cycle WAIT_LOCK reaches timeout: lock wins (-> STABLE).
REQ-027 Counters SHALL be sized from parameters; no counter wraps while in use.

Reset
REQ-028 reset_n=0 SHALL asynchronously force: state=IDLE, pll_resetb=0, sys_reset_n=0, ready=0, fault=0, lock_loss_count=0, retries=0, all counters=0, synchronizer flops=0.
REQ-029 Reset deassertion SHALL take effect on the next clock_in edge; reset_n asserted in any state, including mid-RUN, returns the block to IDLE without glitching sys_reset_n high.

Verification (RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-030 Nominal: enable=1, locked rises 10 cycles after pll_resetb rises -> pll_resetb low 4 cycles, STABLE entered 2 cycles after locked, ready=1 and sys_reset_n=1 after 8 more cycles.
REQ-031 Lock glitch in STABLE: locked low 3 cycles at STABLE cycle 5 -> return to WAIT_LOCK, ready stays 0, no retry counted, RUN reached 8 clean cycles after relock.
REQ-032 Lock loss in RUN: locked drops -> within 3 cycles sys_reset_n=0, ready=0, pll_resetb=0 for 4 cycles, lock_loss_count=1; relock -> RUN again.
REQ-033 Timeout/fault: locked held 0 -> 3 attempts (pll_resetb pulses low 3 times) then fault=1, state=5; enable=0 -> IDLE, fault=0; enable=1 restarts the sequence.
REQ-034 Saturation and reset: 256 RUN lock-loss events -> lock_loss_count=255; then reset_n pulsed low mid-RUN -> all outputs at REQ-028 values immediately (asynchronously).
